// File: rtl/rv32_pkg.sv
// Shared RV32I OoO core definitions used by the ALU reservation station.
//   alu_op_e      : 4-bit ALU opcode encoding (ADD=0 .. AND=9)
//   TAG_W_DEFAULT : default ROB/physical tag width
//   rs_entry_t    : one reservation-station slot
package rv32_pkg;

    localparam int TAG_W_DEFAULT = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef logic [TAG_W_DEFAULT-1:0] rs_tag_t;

    // The opcode is kept as raw bits so that undefined encodings travel
    // through the station unchanged.
    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic        rdy1;
        rs_tag_t     tag1;
        logic [31:0] val1;
        logic        rdy2;
        rs_tag_t     tag2;
        logic [31:0] val2;
        rs_tag_t     dst;
    } rs_entry_t;

endpackage

// File: rtl/alu_rs_pick.sv
// Lowest-index one-hot picker.
//   req_i : request vector (N bits)
//   gnt_o : one-hot grant of the lowest set request bit (all zero if none)
//   any_o : at least one request is set
module alu_rs_pick
    import rv32_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    output logic         any_o
);

    // Two's-complement isolation of the lowest set bit.
    assign gnt_o = req_i & (~req_i + N'(1));
    assign any_o = |req_i;

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds renamed integer ops until both operands are
// available (capturing values off the CDB) and issues one ready op per cycle
// through a registered bundle that drives the ALU inputs directly.
//   clk, rst, flush             : clock, sync active-high reset, mispredict flush
//   disp_valid/disp_ready       : dispatch handshake
//   disp_op, disp_rs*_*, disp_dst_tag : renamed op and its sources
//   cdb_valid/cdb_tag/cdb_data  : result broadcast used for wakeup
//   iss_valid/iss_ready         : issue handshake towards the ALU
//   iss_op, iss_a, iss_b, iss_tag : registered issue bundle
module alu_rs
    import rv32_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = rv32_pkg::TAG_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_op,
    input  logic             disp_rs1_rdy,
    input  logic [TAG_W-1:0] disp_rs1_tag,
    input  logic [31:0]      disp_rs1_val,
    input  logic             disp_rs2_rdy,
    input  logic [TAG_W-1:0] disp_rs2_tag,
    input  logic [31:0]      disp_rs2_val,
    input  logic [TAG_W-1:0] disp_dst_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             iss_valid,
    input  logic             iss_ready,
    output logic [3:0]       iss_op,
    output logic [31:0]      iss_a,
    output logic [31:0]      iss_b,
    output logic [TAG_W-1:0] iss_tag
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t entries_q [DEPTH];
    rs_entry_t entries_d [DEPTH];

    logic [DEPTH-1:0] free_vec, elig_vec, free_gnt, elig_gnt;
    logic             any_free, any_elig;
    logic [IDX_W-1:0] free_idx, elig_idx;

    logic             iss_valid_q, iss_valid_d;
    logic [3:0]       iss_op_q, iss_op_d;
    logic [31:0]      iss_a_q, iss_a_d;
    logic [31:0]      iss_b_q, iss_b_d;
    logic [TAG_W-1:0] iss_tag_q, iss_tag_d;

    rs_tag_t   cdb_tag_w;
    logic      d_rdy1, d_rdy2;
    logic [31:0] d_val1, d_val2;
    rs_entry_t new_entry;
    logic      disp_fire, iss_free, iss_from_rs, iss_from_disp;

    // Entry status vectors come from registered state only.
    always_comb begin
        free_vec = '0;
        elig_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            free_vec[i] = !entries_q[i].valid;
            elig_vec[i] = entries_q[i].valid && entries_q[i].rdy1 && entries_q[i].rdy2;
        end
    end

    alu_rs_pick #(.N(DEPTH)) u_pick_free (
        .req_i (free_vec),
        .gnt_o (free_gnt),
        .any_o (any_free)
    );

    alu_rs_pick #(.N(DEPTH)) u_pick_elig (
        .req_i (elig_vec),
        .gnt_o (elig_gnt),
        .any_o (any_elig)
    );

    always_comb begin
        free_idx = '0;
        elig_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (free_gnt[i]) free_idx = IDX_W'(i);
            if (elig_gnt[i]) elig_idx = IDX_W'(i);
        end
    end

    assign disp_ready = any_free;
    assign cdb_tag_w  = rs_tag_t'(cdb_tag);

    // A source produced on the CDB in the dispatch cycle is captured directly.
    always_comb begin
        d_rdy1 = disp_rs1_rdy || (cdb_valid && (cdb_tag == disp_rs1_tag));
        d_rdy2 = disp_rs2_rdy || (cdb_valid && (cdb_tag == disp_rs2_tag));
        d_val1 = disp_rs1_rdy ? disp_rs1_val : cdb_data;
        d_val2 = disp_rs2_rdy ? disp_rs2_val : cdb_data;
    end

    always_comb begin
        new_entry       = '0;
        new_entry.valid = 1'b1;
        new_entry.op    = disp_op;
        new_entry.rdy1  = d_rdy1;
        new_entry.tag1  = rs_tag_t'(disp_rs1_tag);
        new_entry.val1  = d_val1;
        new_entry.rdy2  = d_rdy2;
        new_entry.tag2  = rs_tag_t'(disp_rs2_tag);
        new_entry.val2  = d_val2;
        new_entry.dst   = rs_tag_t'(disp_dst_tag);
    end

    assign disp_fire   = disp_valid && disp_ready;
    assign iss_free    = !iss_valid_q || iss_ready;
    assign iss_from_rs = iss_free && any_elig;
    // Fast path: with nothing waiting to issue, a fully ready op skips the
    // entry array and lands in the issue register on its dispatch edge.
    assign iss_from_disp = iss_free && !any_elig && disp_fire && d_rdy1 && d_rdy2;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entries_d[i] = entries_q[i];
            if (entries_q[i].valid && cdb_valid) begin
                if (!entries_q[i].rdy1 && (entries_q[i].tag1 == cdb_tag_w)) begin
                    entries_d[i].rdy1 = 1'b1;
                    entries_d[i].val1 = cdb_data;
                end
                if (!entries_q[i].rdy2 && (entries_q[i].tag2 == cdb_tag_w)) begin
                    entries_d[i].rdy2 = 1'b1;
                    entries_d[i].val2 = cdb_data;
                end
            end
        end
        if (iss_from_rs) begin
            entries_d[elig_idx].valid = 1'b0;
        end
        if (disp_fire && !iss_from_disp) begin
            entries_d[free_idx] = new_entry;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) entries_d[i].valid = 1'b0;
        end
    end

    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        iss_tag_d   = iss_tag_q;
        if (iss_from_rs) begin
            iss_valid_d = 1'b1;
            iss_op_d    = entries_q[elig_idx].op;
            iss_a_d     = entries_q[elig_idx].val1;
            iss_b_d     = entries_q[elig_idx].val2;
            iss_tag_d   = TAG_W'(entries_q[elig_idx].dst);
        end else if (iss_from_disp) begin
            iss_valid_d = 1'b1;
            iss_op_d    = disp_op;
            iss_a_d     = d_val1;
            iss_b_d     = d_val2;
            iss_tag_d   = disp_dst_tag;
        end else if (iss_ready) begin
            iss_valid_d = 1'b0;
        end
        if (flush) begin
            iss_valid_d = 1'b0;
            iss_op_d    = '0;
            iss_a_d     = '0;
            iss_b_d     = '0;
            iss_tag_d   = '0;
        end
    end

    // Only the valid bits need reset; payload is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= entries_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q <= 1'b0;
            iss_op_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_tag_q   <= '0;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_tag_q   <= iss_tag_d;
        end
    end

    assign iss_valid = iss_valid_q;
    assign iss_op    = iss_op_q;
    assign iss_a     = iss_a_q;
    assign iss_b     = iss_b_q;
    assign iss_tag   = iss_tag_q;

endmodule

// File: tb/tb_alu_rs.sv
module tb_alu_rs;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        disp_valid, disp_ready;
    logic [3:0]  disp_op;
    logic        disp_rs1_rdy, disp_rs2_rdy;
    logic [4:0]  disp_rs1_tag, disp_rs2_tag, disp_dst_tag;
    logic [31:0] disp_rs1_val, disp_rs2_val;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        iss_valid, iss_ready;
    logic [3:0]  iss_op;
    logic [31:0] iss_a, iss_b;
    logic [4:0]  iss_tag;

    alu_rs #(.DEPTH(4), .TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_tag(disp_rs1_tag), .disp_rs1_val(disp_rs1_val),
        .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_tag(disp_rs2_tag), .disp_rs2_val(disp_rs2_val),
        .disp_dst_tag(disp_dst_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
        .iss_a(iss_a), .iss_b(iss_b), .iss_tag(iss_tag)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        bit          v;
        logic [3:0]  op;
        bit          r1;
        logic [4:0]  t1;
        logic [31:0] d1;
        bit          r2;
        logic [4:0]  t2;
        logic [31:0] d2;
        logic [4:0]  dst;
    } slot_t;

    slot_t       slots [4];
    bit          m_init = 1'b0;
    bit          m_iv;
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [4:0]  m_tag;
    bit          m_dr;

    always @(posedge clk) begin : model
        int e, f;
        bit full, accept, port_free, o1, o2;
        logic [31:0] x1, x2;
        if (rst || flush) begin
            for (int i = 0; i < 4; i++) slots[i].v = 1'b0;
            m_iv = 0; m_op = 0; m_a = 0; m_b = 0; m_tag = 0;
            if (rst) m_init = 1'b1;
        end else begin
            full = 1'b1;
            e = -1;
            f = -1;
            for (int i = 3; i >= 0; i--) begin
                if (!slots[i].v) begin full = 1'b0; f = i; end
                if (slots[i].v && slots[i].r1 && slots[i].r2) e = i;
            end
            accept    = disp_valid && !full;
            port_free = !m_iv || iss_ready;
            o1 = disp_rs1_rdy; x1 = disp_rs1_val;
            o2 = disp_rs2_rdy; x2 = disp_rs2_val;
            if (!o1 && cdb_valid && cdb_tag == disp_rs1_tag) begin o1 = 1; x1 = cdb_data; end
            if (!o2 && cdb_valid && cdb_tag == disp_rs2_tag) begin o2 = 1; x2 = cdb_data; end
            if (port_free && e >= 0) begin
                m_iv = 1; m_op = slots[e].op; m_a = slots[e].d1; m_b = slots[e].d2; m_tag = slots[e].dst;
                slots[e].v = 0;
            end else if (port_free && accept && o1 && o2) begin
                m_iv = 1; m_op = disp_op; m_a = x1; m_b = x2; m_tag = disp_dst_tag;
                accept = 0;
            end else if (iss_ready) begin
                m_iv = 0;
            end
            if (cdb_valid) begin
                for (int i = 0; i < 4; i++) begin
                    if (slots[i].v && !slots[i].r1 && slots[i].t1 == cdb_tag) begin slots[i].r1 = 1; slots[i].d1 = cdb_data; end
                    if (slots[i].v && !slots[i].r2 && slots[i].t2 == cdb_tag) begin slots[i].r2 = 1; slots[i].d2 = cdb_data; end
                end
            end
            if (accept) begin
                slots[f].v = 1; slots[f].op = disp_op;
                slots[f].r1 = o1; slots[f].t1 = disp_rs1_tag; slots[f].d1 = x1;
                slots[f].r2 = o2; slots[f].t2 = disp_rs2_tag; slots[f].d2 = x2;
                slots[f].dst = disp_dst_tag;
            end
        end
        m_dr = 1'b0;
        for (int i = 0; i < 4; i++) if (!slots[i].v) m_dr = 1'b1;
    end

    // Model compare, every cycle once the model has seen reset.
    always @(negedge clk) begin
        if (m_init) begin
            chk("iss_valid", {31'd0, iss_valid}, {31'd0, m_iv});
            chk("disp_ready", {31'd0, disp_ready}, {31'd0, m_dr});
            if (m_iv) begin
                chk("iss_op", {28'd0, iss_op}, {28'd0, m_op});
                chk("iss_a", iss_a, m_a);
                chk("iss_b", iss_b, m_b);
                chk("iss_tag", {27'd0, iss_tag}, {27'd0, m_tag});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        disp_valid = 0; cdb_valid = 0; flush = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic r1, input logic [4:0] t1, input logic [31:0] v1,
                        input logic r2, input logic [4:0] t2, input logic [31:0] v2, input logic [4:0] dst);
        disp_valid = 1; disp_op = op;
        disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_val = v1;
        disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_val = v2;
        disp_dst_tag = dst;
    endtask

    task automatic bcast(input logic [4:0] t, input logic [31:0] d);
        cdb_valid = 1; cdb_tag = t; cdb_data = d;
    endtask

    task automatic lit_iss(input string nm, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag);
        chk({nm, "_valid"}, {31'd0, iss_valid}, 32'd1);
        chk({nm, "_op"}, {28'd0, iss_op}, {28'd0, op});
        chk({nm, "_a"}, iss_a, a);
        chk({nm, "_b"}, iss_b, b);
        chk({nm, "_tag"}, {27'd0, iss_tag}, {27'd0, tag});
    endtask

    initial begin
        rst = 1; iss_ready = 1;
        idle();
        disp(4'd0, 0, 0, 0, 0, 0, 0, 0);
        disp_valid = 0;
        cdb_tag = 0; cdb_data = 0;
        repeat (2) step();

        // 1: reset state, then ready op issues on the next cycle
        chk("rst_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("rst_disp_ready", {31'd0, disp_ready}, 32'd1);
        chk("rst_iss_a", iss_a, 32'd0);
        chk("rst_iss_tag", {27'd0, iss_tag}, 32'd0);
        rst = 0;
        disp(4'd0, 1, 0, 32'd5, 1, 0, 32'd7, 5'd3);
        step(); idle();
        lit_iss("t1", 4'd0, 32'd5, 32'd7, 5'd3);

        // 2: waiting source woken by the CDB
        disp(4'd1, 0, 5'd9, 32'hDEAD, 1, 0, 32'd1, 5'd4);
        step(); idle();
        for (int k = 0; k < 3; k++) begin
            chk("t2_wait", {31'd0, iss_valid}, 32'd0);
            step();
        end
        bcast(5'd9, 32'h10);
        step(); idle();
        chk("t2_wake1", {31'd0, iss_valid}, 32'd0);
        step();
        lit_iss("t2", 4'd1, 32'h10, 32'd1, 5'd4);

        // 3: CDB bypass at dispatch
        disp(4'd5, 0, 5'd4, 32'hDEAD, 1, 0, 32'd3, 5'd8);
        bcast(5'd4, 32'hAB);
        step(); idle();
        lit_iss("t3", 4'd5, 32'hAB, 32'd3, 5'd8);
        step();

        // 4: fill, stall, release
        for (int k = 0; k < 4; k++) begin
            disp(4'd0, 0, 5'd12, 32'hDEAD, 1, 0, 32'(k), 5'(16 + k));
            step();
        end
        idle();
        chk("t4_full", {31'd0, disp_ready}, 32'd0);
        iss_ready = 0;
        bcast(5'd12, 32'h55);
        step(); idle();
        chk("t4_full_eligible", {31'd0, disp_ready}, 32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            lit_iss("t4_stall", 4'd0, 32'h55, 32'd0, 5'd16);
            chk("t4_stall_ready", {31'd0, disp_ready}, 32'd1);
            step();
        end
        iss_ready = 1;
        for (int k = 1; k < 4; k++) begin
            step();
            lit_iss("t4_drain", 4'd0, 32'h55, 32'(k), 5'(16 + k));
        end
        step();
        chk("t4_empty", {31'd0, iss_valid}, 32'd0);

        // 6: two entries woken by one broadcast issue lowest index first
        disp(4'd8, 0, 5'd6, 0, 1, 0, 32'd1, 5'd1); step();
        disp(4'd8, 0, 5'd30, 0, 1, 0, 32'd2, 5'd2); step();
        disp(4'd8, 0, 5'd6, 0, 1, 0, 32'd3, 5'd5); step();
        idle();
        bcast(5'd6, 32'hCAFE);
        step(); idle();
        step();
        lit_iss("t6_first", 4'd8, 32'hCAFE, 32'd1, 5'd1);
        step();
        lit_iss("t6_second", 4'd8, 32'hCAFE, 32'd3, 5'd5);
        bcast(5'd30, 32'h77);
        step(); idle();
        step();
        lit_iss("t6_third", 4'd8, 32'h77, 32'd2, 5'd2);
        step();

        // 5: flush beats dispatch and wakeup
        disp(4'd2, 0, 5'd13, 0, 1, 0, 32'd9, 5'd20); step();
        disp(4'd3, 0, 5'd13, 0, 1, 0, 32'd9, 5'd21); step();
        disp(4'd4, 1, 0, 32'd1, 1, 0, 32'd2, 5'd22);
        bcast(5'd13, 32'h99);
        flush = 1;
        step(); idle();
        chk("t5_iss_valid", {31'd0, iss_valid}, 32'd0);
        chk("t5_disp_ready", {31'd0, disp_ready}, 32'd1);
        bcast(5'd13, 32'h99);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t5_no_issue", {31'd0, iss_valid}, 32'd0);
        end
        idle();

        // Random traffic against the model
        for (int k = 0; k < 1500; k++) begin
            disp_valid   = ($urandom_range(0, 2) != 0);
            disp_op      = 4'($urandom_range(0, 15));
            disp_rs1_rdy = $urandom_range(0, 1) == 1;
            disp_rs1_tag = 5'($urandom_range(0, 7));
            disp_rs1_val = $urandom;
            disp_rs2_rdy = $urandom_range(0, 1) == 1;
            disp_rs2_tag = 5'($urandom_range(0, 7));
            disp_rs2_val = $urandom;
            disp_dst_tag = 5'($urandom_range(0, 31));
            cdb_valid    = $urandom_range(0, 1) == 1;
            cdb_tag      = 5'($urandom_range(0, 7));
            cdb_data     = $urandom;
            iss_ready    = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 63) == 0);
            step();
        end
        idle();
        iss_ready = 1;
        repeat (6) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
